// File: rtl/fir_stim_gen_pkg.sv
// fir_pkg: shared types and constants for the FIR stimulus generator.
// Holds the stimulus mode and FSM state encodings, the LFSR feedback
// polynomial, the default LFSR seed, and the LFSR step/seed helpers.
package fir_pkg;

  // Stimulus waveform selected at the start of a run
  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'd0,
    MODE_STEP    = 2'd1,
    MODE_NOISE   = 2'd2,
    MODE_RAMP    = 2'd3
  } stim_mode_t;

  // Generator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stim_state_t;

  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One Galois shift: shift right, fold the outgoing bit back through the taps
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_POLY;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
    logic [15:0] fixed;
    if (seed == 16'h0000) begin
      fixed = 16'h0001;
    end else begin
      fixed = seed;
    end
    return fixed;
  endfunction

endpackage

// File: rtl/fir_stim_gen_if.sv
// fir_stim_gen_if: control and sample stream between a stimulus source
// (master side drives the run request, slave side is the generator).
interface fir_stim_gen_if #(
  parameter int IN_INTE_WL = 4,
  parameter int IN_FRAC_WL = 8,
  parameter int LEN_WL     = 16
);

  logic                                 start;
  logic                                 abort;
  logic [1:0]                           mode;
  logic signed [IN_INTE_WL-1:-IN_FRAC_WL] amplitude;
  logic [LEN_WL-1:0]                    length;
  logic                                 hold;
  logic signed [IN_INTE_WL-1:-IN_FRAC_WL] data_out;
  logic                                 out_valid;
  logic                                 busy;
  logic                                 done;

  modport master (
    output start, abort, mode, amplitude, length, hold,
    input  data_out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, mode, amplitude, length, hold,
    output data_out, out_valid, busy, done
  );

endinterface

// File: rtl/fir_stim_gen_lfsr.sv
// fir_lfsr: 16-bit Galois LFSR with synchronous reload and step enable.
// Only built when FIR_STIM_LFSR_EN is defined (noise mode present).
`ifdef FIR_STIM_LFSR_EN
module fir_lfsr
  import fir_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  output logic [15:0] state
);

  localparam logic [15:0] SEED_EFF = lfsr_seed_fix(SEED);

  logic [15:0] state_r;

  // Reload has priority over stepping; otherwise hold the current value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SEED_EFF;
    end else if (load) begin
      state_r <= SEED_EFF;
    end else if (enable) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule
`endif

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: test-stimulus source for a FIR filter input.
// Produces impulse, step, ramp or noise runs of a programmed length with
// stall (hold) and abort support. All outputs are registered.
// Build option: define FIR_STIM_LFSR_EN to include the LFSR noise source;
// without it, noise mode emits zeros with normal run timing.
module fir_stim_gen
  import fir_pkg::*;
#(
  parameter int          IN_INTE_WL = 4,
  parameter int          IN_FRAC_WL = 8,
  parameter int          LEN_WL     = 16,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input logic           clk,
  input logic           rst,
  fir_stim_gen_if.slave bus
);

  localparam int                W       = IN_INTE_WL + IN_FRAC_WL;
  localparam logic [LEN_WL-1:0] LEN_ONE = {{(LEN_WL-1){1'b0}}, 1'b1};

  stim_state_t       state_r, state_s;
  stim_mode_t        mode_r, mode_s;
  logic [W-1:0]      amp_r, amp_s;
  logic [LEN_WL-1:0] len_r, len_s;
  logic [LEN_WL-1:0] k_r, k_s;
  logic [W-1:0]      data_r, data_s;
  logic [W-1:0]      sample_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

`ifdef FIR_STIM_LFSR_EN
  logic        lfsr_load_s;
  logic        lfsr_en_s;
  logic [15:0] lfsr_state_s;
  logic [15:0] lfsr_next_s;

  fir_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load_s),
    .enable (lfsr_en_s),
    .state  (lfsr_state_s)
  );

  // A noise sample is the value the LFSR steps to on that emission
  assign lfsr_next_s = lfsr_step(lfsr_state_s);
`endif

  // Sample value for the current index k under the latched mode
  always_comb begin
    sample_s = {W{1'b0}};
    case (mode_r)
      MODE_IMPULSE: begin
        if (k_r == {LEN_WL{1'b0}}) begin
          sample_s = amp_r;
        end else begin
          sample_s = {W{1'b0}};
        end
      end
      MODE_STEP: begin
        sample_s = amp_r;
      end
      MODE_RAMP: begin
        // Wraps modulo 2^W by truncation
        sample_s = amp_r + W'(k_r);
      end
      MODE_NOISE: begin
`ifdef FIR_STIM_LFSR_EN
        sample_s = W'(lfsr_next_s);
`else
        sample_s = {W{1'b0}};
`endif
      end
      default: begin
        sample_s = {W{1'b0}};
      end
    endcase
  end

  // Next-state and next-output decode for the IDLE/RUN/DONE controller
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    amp_s   = amp_r;
    len_s   = len_r;
    k_s     = k_r;
    data_s  = data_r;
    valid_s = 1'b0;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef FIR_STIM_LFSR_EN
    lfsr_load_s = 1'b0;
    lfsr_en_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        // abort is meaningless here, so start alone decides
        if (bus.start) begin
          mode_s = stim_mode_t'(bus.mode);
          amp_s  = bus.amplitude;
          len_s  = bus.length;
          k_s    = {LEN_WL{1'b0}};
          busy_s = 1'b1;
`ifdef FIR_STIM_LFSR_EN
          lfsr_load_s = 1'b1;
`endif
          if (bus.length == {LEN_WL{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // abort outranks both hold and the final-sample transition
        if (bus.abort) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          k_s     = {LEN_WL{1'b0}};
        end else if (bus.hold) begin
          state_s = ST_RUN;
        end else begin
          data_s  = sample_s;
          valid_s = 1'b1;
          k_s     = k_r + LEN_ONE;
`ifdef FIR_STIM_LFSR_EN
          if (mode_r == MODE_NOISE) begin
            lfsr_en_s = 1'b1;
          end else begin
            lfsr_en_s = 1'b0;
          end
`endif
          if (k_r == (len_r - LEN_ONE)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        // First DONE cycle raises the done pulse, the second returns to IDLE
        if (done_r) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, run context and output registers; reset clears all of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_IMPULSE;
      amp_r   <= {W{1'b0}};
      len_r   <= {LEN_WL{1'b0}};
      k_r     <= {LEN_WL{1'b0}};
      data_r  <= {W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      amp_r   <= amp_s;
      len_r   <= len_s;
      k_r     <= k_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.data_out  = data_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: scoreboard bench for fir_stim_gen.
// Expected samples are pushed when a run is launched and popped as the
// generator emits valid samples.
module tb_fir_stim_gen;

  localparam int IW = 4;
  localparam int FW = 8;
  localparam int LW = 16;
  localparam int W  = IW + FW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fir_stim_gen_if #(.IN_INTE_WL(IW), .IN_FRAC_WL(FW), .LEN_WL(LW)) bus ();

  fir_stim_gen #(
    .IN_INTE_WL (IW),
    .IN_FRAC_WL (FW),
    .LEN_WL     (LW),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         obs_valid_q[$];
  logic [W-1:0] obs_data_q[$];
  logic         obs_busy_q[$];
  logic         obs_done_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side LFSR reference
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0] == 1'b1) t = t ^ 16'hB400;
    return t;
  endfunction

  // Push the expected sample sequence of a run
  task automatic push_expected(input logic [1:0] m, input logic [W-1:0] a, input int n);
    logic [15:0]  lf;
    logic [W-1:0] e;
    lf = 16'hACE1;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd0: e = (k == 0) ? a : {W{1'b0}};
        2'd1: e = a;
        2'd3: e = a + k[W-1:0];
        default: begin
`ifdef FIR_STIM_LFSR_EN
          lf = ref_lfsr(lf);
          e  = lf[W-1:0];
`else
          e  = {W{1'b0}};
`endif
        end
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [W-1:0] a, input logic [LW-1:0] n);
    bus.mode      = m;
    bus.amplitude = a;
    bus.length    = n;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Advance n cycles applying hold_mask[i], recording the outputs after each edge
  task automatic run_cycles(input int n, input logic [31:0] hold_mask);
    obs_valid_q.delete();
    obs_data_q.delete();
    obs_busy_q.delete();
    obs_done_q.delete();
    for (int i = 0; i < n; i++) begin
      bus.hold = hold_mask[i];
      tick();
      obs_valid_q.push_back(bus.out_valid);
      obs_data_q.push_back(bus.data_out);
      obs_busy_q.push_back(bus.busy);
      obs_done_q.push_back(bus.done);
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.mode = 2'd0; bus.amplitude = '0; bus.length = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (bus.data_out !== 12'h000) begin errors++; $display("FAIL reset_data got %0h want 0", bus.data_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", bus.busy); end
  endtask

  // Impulse, ramp and step-with-hold runs from a compact table
  task automatic test_patterns();
    logic [1:0]   t_mode[3] = '{2'd0, 2'd3, 2'd1};
    logic [W-1:0] t_amp[3]  = '{12'h100, 12'h7FE, 12'hF80};
    int           t_len[3]  = '{4, 4, 3};
    logic [31:0]  t_hold[3] = '{32'h0, 32'h0, 32'hA};
    logic [W-1:0] e;
    int nvalid, ndone, done_idx, last_v;
    logic busy_ok;
    for (int t = 0; t < 3; t++) begin
      exp_q.delete();
      push_expected(t_mode[t], t_amp[t], t_len[t]);
      launch(t_mode[t], t_amp[t], t_len[t][LW-1:0]);
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL pat%0d_start busy=%0b valid=%0b want busy=1 valid=0", t, bus.busy, bus.out_valid);
      end
      run_cycles(12, t_hold[t]);
      nvalid = 0; ndone = 0; done_idx = -1; last_v = -1; busy_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (obs_valid_q[i]) begin
          nvalid++; last_v = i; checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL pat%0d_extra got %0h want none", t, obs_data_q[i]);
          end else begin
            e = exp_q.pop_front();
            if (obs_data_q[i] !== e) begin errors++; $display("FAIL pat%0d_data[%0d] got %0h want %0h", t, i, obs_data_q[i], e); end
          end
        end
        if (t_hold[t][i]) begin
          checks++;
          if (obs_valid_q[i] !== 1'b0) begin errors++; $display("FAIL pat%0d_hold[%0d] got valid=%0b want 0", t, i, obs_valid_q[i]); end
        end
        if (obs_done_q[i]) begin ndone++; if (done_idx < 0) done_idx = i; end
        if ((done_idx < 0 || done_idx == i) && obs_busy_q[i] !== 1'b1) busy_ok = 1'b0;
      end
      checks++; if (nvalid != t_len[t]) begin errors++; $display("FAIL pat%0d_count got %0d want %0d", t, nvalid, t_len[t]); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL pat%0d_done_cnt got %0d want 1", t, ndone); end
      checks++; if (done_idx != last_v + 1) begin errors++; $display("FAIL pat%0d_done_pos got %0d want %0d", t, done_idx, last_v + 1); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL pat%0d_busy got low want high during run", t); end
      checks++; if (obs_busy_q[11] !== 1'b0) begin errors++; $display("FAIL pat%0d_end_busy got %0b want 0", t, obs_busy_q[11]); end
    end
  endtask

  task automatic test_zero_length();
    int nvalid = 0;
    int ndone = 0;
    launch(2'd1, 12'h123, 16'd0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zlen_start_valid got %0b want 0", bus.out_valid); end
    run_cycles(4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (obs_valid_q[i]) nvalid++;
      if (obs_done_q[i]) ndone++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL zlen_valid got %0d want 0", nvalid); end
    checks++; if (obs_done_q[0] !== 1'b1) begin errors++; $display("FAIL zlen_done_edge got %0b want 1", obs_done_q[0]); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL zlen_done_cnt got %0d want 1", ndone); end
    checks++; if (obs_busy_q[1] !== 1'b0) begin errors++; $display("FAIL zlen_busy got %0b want 0", obs_busy_q[1]); end
  endtask

  task automatic test_abort();
    int nvalid = 0;
    int ndone = 0;
    logic [W-1:0] e;
    exp_q.delete();
    push_expected(2'd1, 12'h010, 10);
    launch(2'd1, 12'h010, 16'd10);
    run_cycles(2, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      e = exp_q.pop_front();
      if (obs_valid_q[i] !== 1'b1 || obs_data_q[i] !== e) begin
        errors++; $display("FAIL abort_pre[%0d] got v=%0b d=%0h want v=1 d=%0h", i, obs_valid_q[i], obs_data_q[i], e);
      end
    end
    bus.abort = 1'b1; bus.hold = 1'b1;
    tick();
    bus.abort = 1'b0; bus.hold = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_edge got busy=%0b valid=%0b done=%0b want 0 0 0", bus.busy, bus.out_valid, bus.done);
    end
    run_cycles(6, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (obs_valid_q[i]) nvalid++;
      if (obs_done_q[i]) ndone++;
    end
    checks++; if (nvalid != 0 || ndone != 0) begin errors++; $display("FAIL abort_after got valid=%0d done=%0d want 0 0", nvalid, ndone); end
    // Abort on the would-be last sample of a one-sample run
    launch(2'd1, 12'h020, 16'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_last got valid=%0b busy=%0b want 0 0", bus.out_valid, bus.busy);
    end
    run_cycles(4, 32'h0);
    ndone = 0;
    for (int i = 0; i < 4; i++) if (obs_done_q[i]) ndone++;
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_last_done got %0d want 0", ndone); end
  endtask

  // start held high through RUN and DONE must not queue a second run
  task automatic test_back_to_back();
    int nvalid = 0;
    int ndone = 0;
    logic [W-1:0] e;
    exp_q.delete();
    push_expected(2'd3, 12'h000, 3);
    launch(2'd3, 12'h000, 16'd3);
    bus.start = 1'b1; bus.mode = 2'd1; bus.length = 16'd5; bus.amplitude = 12'h555;
    run_cycles(5, 32'h0);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (obs_valid_q[i]) begin
        nvalid++; checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
        if (obs_data_q[i] !== e) begin errors++; $display("FAIL b2b_data[%0d] got %0h want %0h", i, obs_data_q[i], e); end
      end
      if (obs_done_q[i]) ndone++;
    end
    checks++; if (nvalid != 3 || ndone != 1) begin errors++; $display("FAIL b2b_counts got valid=%0d done=%0d want 3 1", nvalid, ndone); end
    run_cycles(3, 32'h0);
    nvalid = 0;
    for (int i = 0; i < 3; i++) if (obs_valid_q[i] || obs_busy_q[i]) nvalid++;
    checks++; if (nvalid != 0) begin errors++; $display("FAIL b2b_no_requeue got %0d active cycles want 0", nvalid); end
  endtask

  task automatic test_start_abort();
    int nvalid = 0;
    logic [W-1:0] e;
    exp_q.delete();
    push_expected(2'd1, 12'h0AA, 2);
    bus.abort = 1'b1;
    launch(2'd1, 12'h0AA, 16'd2);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL startabort_busy got %0b want 1", bus.busy); end
    run_cycles(5, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (obs_valid_q[i]) begin
        nvalid++; checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
        if (obs_data_q[i] !== e) begin errors++; $display("FAIL startabort_data[%0d] got %0h want %0h", i, obs_data_q[i], e); end
      end
    end
    checks++; if (nvalid != 2) begin errors++; $display("FAIL startabort_count got %0d want 2", nvalid); end
  endtask

  task automatic test_noise();
    logic [W-1:0] first_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] e;
    logic [W-1:0] exp_first;
`ifdef FIR_STIM_LFSR_EN
    exp_first = 12'h270;
`else
    exp_first = 12'h000;
`endif
    for (int r = 0; r < 2; r++) begin
      exp_q.delete();
      got_q.delete();
      push_expected(2'd2, 12'h3C3, 8);
      launch(2'd2, 12'h3C3, 16'd8);
      run_cycles(12, 32'h0);
      for (int i = 0; i < 12; i++) begin
        if (obs_valid_q[i]) begin
          checks++;
          got_q.push_back(obs_data_q[i]);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
          if (obs_data_q[i] !== e) begin errors++; $display("FAIL noise%0d_data[%0d] got %0h want %0h", r, i, obs_data_q[i], e); end
        end
      end
      checks++; if (got_q.size() != 8) begin errors++; $display("FAIL noise%0d_count got %0d want 8", r, got_q.size()); end
      if (r == 0) begin
        first_q = got_q;
        checks++; if (got_q.size() == 0 || got_q[0] !== exp_first) begin
          errors++; $display("FAIL noise_first got %0h want %0h", (got_q.size() != 0) ? got_q[0] : 12'hFFF, exp_first);
        end
      end else begin
        checks++; if (got_q != first_q) begin errors++; $display("FAIL noise_repeat got differing sequences want identical"); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nvalid = 0;
    logic [W-1:0] e;
    launch(2'd3, 12'h005, 16'd10);
    run_cycles(3, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.data_out !== 12'h000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got d=%0h v=%0b b=%0b dn=%0b want all 0", bus.data_out, bus.out_valid, bus.busy, bus.done);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(3, 32'h0);
    checks++; if (obs_busy_q[2] !== 1'b0 || obs_valid_q[2] !== 1'b0) begin
      errors++; $display("FAIL midrst_wait got busy=%0b valid=%0b want 0 0", obs_busy_q[2], obs_valid_q[2]);
    end
    exp_q.delete();
    push_expected(2'd3, 12'h005, 3);
    launch(2'd3, 12'h005, 16'd3);
    run_cycles(8, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (obs_valid_q[i]) begin
        nvalid++; checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
        if (obs_data_q[i] !== e) begin errors++; $display("FAIL midrst_data[%0d] got %0h want %0h", i, obs_data_q[i], e); end
      end
    end
    checks++; if (nvalid != 3) begin errors++; $display("FAIL midrst_count got %0d want 3", nvalid); end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_zero_length();
    test_abort();
    test_back_to_back();
    test_start_abort();
    test_noise();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
